bf_program_loader: RTL and testbench
====================================

Name: bf_program_loader

Overview:
- Upstream feeder for the BF machine's program memory.
- Operator dials an ASCII character on the 8 data switches and presses an enter key; the block translates the character to a 4-bit opcode and writes it to the next program-memory address.
- Tracks bracket nesting. On the finish key, it appends a terminating END opcode and raises input_done, which drives the machine's PMInputDone.
- Malformed programs latch an error, and input_done is never raised.

Parameters:
ADDR_W, 16, program-memory address width (matches the PC width)
MAX_LEN, 1024, program-memory words usable, including the END word
DEPTH_W, 8, width of the bracket-nesting counter

Ports:
clock  input  1  system clock
reset  input  1  asynchronous active-low reset
switches  input  8  ASCII character from the data switches
enter  input  1  enter key, level, asynchronous to clock
finish  input  1  finish key, level, asynchronous to clock
pm_addr  output  ADDR_W  program-memory write address
pm_data  output  4  opcode to write
pm_wren  output  1  program-memory write enable, one-cycle pulse
input_done  output  1  program loaded; held high until reset
bracket_err  output  1  unbalanced-bracket or overflow error; held until reset
full  output  1  character storage exhausted
length  output  ADDR_W  number of opcodes written, excluding END

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; address counter 0; depth counter 0.
  - Synchronisers cleared; state LOAD.
  - Reset asserted mid-load discards all progress; any in-flight write is aborted with pm_wren=0.
- Key inputs:
  - enter and finish each pass through a 2-flop synchroniser and a rising-edge detector.
  - The 0->1 transition of the synchronised level produces a one-cycle event.
  - Holding a key produces one event only.
- Opcode map (ASCII -> opcode):
  - '>'(0x3E)->1, '<'(0x3C)->2, '+'(0x2B)->3, '-'(0x2D)->4
  - '.'(0x2E)->5, ','(0x2C)->6, '['(0x5B)->7, ']'(0x5D)->8
  - END=0.
  - Any other character is ignored: no write, no counter change.
- States: LOAD, WRITE, TERM, DONE, ERROR.
  - LOAD:
    - An enter event with a valid character and full=0 registers the opcode and moves to WRITE.
    - An enter event while full=1, or with an invalid character, is dropped.
    - A finish event goes to TERM if depth=0, else to ERROR.
    - If enter and finish events occur in the same cycle, finish wins and the character is dropped.
  - WRITE (1 cycle):
    - pm_wren=1, pm_addr=current address, pm_data=opcode.
    - Address and length increment at the end of the cycle.
    - '[' increments depth.
    - ']' decrements depth.
    - Returns to LOAD.
  - ']' at depth 0, or '[' at depth 2^DEPTH_W-1:
    - Detected in LOAD; go to ERROR instead of WRITE.
    - No write; address unchanged.
  - TERM (1 cycle): pm_wren=1, pm_data=0, pm_addr=current address. Go to DONE.
  - DONE:
    - input_done=1.
    - All key events ignored.
    - pm_wren=0.
  - ERROR:
    - bracket_err=1, input_done=0.
    - Key events ignored until reset.
- Latency:
  - A raw enter rise before clock edge k gives the synchronised level at edge k+1, the event at edge k+2, and pm_wren high in the cycle after edge k+3.
  - Identical latency for finish to the TERM write.
- Full:
  - full=1 when address = MAX_LEN-1; that slot is reserved for END.
  - A finish event while full still writes END at address MAX_LEN-1.
- Width rules:
  - Address and length are ADDR_W-bit unsigned.
  - MAX_LEN ≤ 2^ADDR_W, so the address never wraps.
  - Depth is DEPTH_W-bit unsigned and never wraps, because the error trap fires first.
- pm_addr holds its last value when pm_wren=0; pm_data is don't-care then.

Test Plan:
- Simple program:
  - Stimulus: enter "+", "+", "." then finish.
  - Writes: addr0=3, addr1=3, addr2=5, addr3=0.
  - Then input_done=1, length=3, bracket_err=0.
- Loop with ignored character:
  - Stimulus: enter "[", "-", "x"(0x78), "]" then finish.
  - Writes: addr0=7, addr1=4, addr2=8, addr3=0.
  - No write for 'x'; length=3.
- Bracket errors:
  - Stimulus A: "]" first → bracket_err=1, no pm_wren pulse; a later finish leaves input_done=0.
  - Stimulus B: "[" then finish → bracket_err=1, and no END write occurs.
- Full:
  - Stimulus: MAX_LEN=4; enter "+" five times, then finish.
  - Three writes at addr0-2; full=1 after the third.
  - 4th and 5th are dropped; END at addr3; length=3.
- Key handling:
  - Enter held high 50 cycles → exactly one pm_wren pulse, 3 cycles after the first sampled high.
  - Enter and finish rising together with "+" and depth 0 → only END written at addr0; length=0.
- Reset mid-load:
  - Stimulus: after 2 writes, pulse reset low for 1 cycle.
  - All outputs return to 0.
  - The next "." is written at addr0.

Source files
------------

// File: rtl/bf_program_loader.sv
// Program-memory loader for the BF machine: turns switch characters into opcodes,
// tracks bracket nesting and appends END on finish.
module bf_program_loader #(
    parameter int ADDR_W  = 16,
    parameter int MAX_LEN = 1024,
    parameter int DEPTH_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        switches,
    input  logic              enter,
    input  logic              finish,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [3:0]        pm_data,
    output logic              pm_wren,
    output logic              input_done,
    output logic              bracket_err,
    output logic              full,
    output logic [ADDR_W-1:0] length
);

    typedef enum logic [2:0] {LOAD, WRITE, TERM, DONE, ERROR} state_t;

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(MAX_LEN - 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [3:0]         OP_OPEN   = 4'd7;
    localparam logic [3:0]         OP_CLOSE  = 4'd8;

    state_t             state, nextState;
    logic [2:0]         enterSync, finishSync;
    logic               enterEvt, finishEvt;
    logic [ADDR_W-1:0]  addr, pmAddrReg;
    logic [DEPTH_W-1:0] depth;
    logic [3:0]         opReg;
    logic               captureOp;
    logic [4:0]         decoded;

    // Returns {valid, opcode}; unknown characters decode as invalid.
    function automatic logic [4:0] decodeChar(input logic [7:0] ch);
        logic [4:0] r;
        case (ch)
            8'h3E:   r = {1'b1, 4'd1};
            8'h3C:   r = {1'b1, 4'd2};
            8'h2B:   r = {1'b1, 4'd3};
            8'h2D:   r = {1'b1, 4'd4};
            8'h2E:   r = {1'b1, 4'd5};
            8'h2C:   r = {1'b1, 4'd6};
            8'h5B:   r = {1'b1, 4'd7};
            8'h5D:   r = {1'b1, 4'd8};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    assign decoded = decodeChar(switches);

    // Key synchronisers: [0],[1] resynchronise, [2] remembers the previous level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enterSync  <= '0;
            finishSync <= '0;
            enterEvt   <= 1'b0;
            finishEvt  <= 1'b0;
        end else begin
            enterSync  <= {enterSync[1:0], enter};
            finishSync <= {finishSync[1:0], finish};
            enterEvt   <= enterSync[1] & ~enterSync[2];
            finishEvt  <= finishSync[1] & ~finishSync[2];
        end
    end

    always_comb begin
        nextState = state;
        captureOp = 1'b0;
        case (state)
            LOAD: begin
                if (finishEvt) begin
                    nextState = (depth == '0) ? TERM : ERROR;
                end else if (enterEvt && !full && decoded[4]) begin
                    if ((decoded[3:0] == OP_CLOSE && depth == '0) ||
                        (decoded[3:0] == OP_OPEN && depth == DEPTH_MAX)) begin
                        nextState = ERROR;
                    end else begin
                        nextState = WRITE;
                        captureOp = 1'b1;
                    end
                end
            end
            WRITE:   nextState = LOAD;
            TERM:    nextState = DONE;
            DONE:    nextState = DONE;
            ERROR:   nextState = ERROR;
            default: nextState = LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            addr      <= '0;
            depth     <= '0;
            opReg     <= '0;
            pmAddrReg <= '0;
        end else begin
            state <= nextState;
            if (captureOp) opReg <= decoded[3:0];
            // pm_addr is latched on entry to a write state so it holds afterwards.
            if (nextState == WRITE || nextState == TERM) pmAddrReg <= addr;
            if (state == WRITE) begin
                addr <= addr + 1'b1;
                if (opReg == OP_OPEN)       depth <= depth + 1'b1;
                else if (opReg == OP_CLOSE) depth <= depth - 1'b1;
            end
        end
    end

    assign pm_wren     = (state == WRITE) || (state == TERM);
    assign pm_data     = (state == TERM) ? 4'd0 : opReg;
    assign pm_addr     = pmAddrReg;
    assign input_done  = (state == DONE);
    assign bracket_err = (state == ERROR);
    assign full        = (addr == LAST_ADDR);
    assign length      = addr;

endmodule

// File: tb/tb_bf_program_loader.sv
// Scoreboard bench for bf_program_loader: a character-level model predicts writes and flags.
module tb_bf_program_loader;

    localparam int ADDR_W  = 4;
    localparam int MAX_LEN = 8;
    localparam int DEPTH_W = 2;
    localparam int DEPTH_MAX = (1 << DEPTH_W) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        switches;
    logic              enter, finish;
    logic [ADDR_W-1:0] pm_addr;
    logic [3:0]        pm_data;
    logic              pm_wren, input_done, bracket_err, full;
    logic [ADDR_W-1:0] length;

    int errors = 0;
    int checks = 0;

    // Expected writes, encoded as addr*16 + data.
    int expQ[$];
    int mAddr, mDepth;
    bit mDone, mErr;
    string opChars = "><+-.,[]";
    string pool    = "><+-.,[]x[]";

    bf_program_loader #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .DEPTH_W(DEPTH_W)) dut (
        .clock(clock), .reset(reset), .switches(switches), .enter(enter), .finish(finish),
        .pm_addr(pm_addr), .pm_data(pm_data), .pm_wren(pm_wren), .input_done(input_done),
        .bracket_err(bracket_err), .full(full), .length(length)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the program as a sequence of characters and a finish.
    task automatic modelReset();
        mAddr = 0; mDepth = 0; mDone = 0; mErr = 0;
        expQ.delete();
    endtask

    task automatic modelEnter(input byte c);
        int op;
        op = 0;
        if (mDone || mErr || mAddr == MAX_LEN - 1) return;
        for (int i = 0; i < opChars.len(); i++)
            if (opChars[i] == c) op = i + 1;
        if (op == 0) return;
        if ((op == 8 && mDepth == 0) || (op == 7 && mDepth == DEPTH_MAX)) begin
            mErr = 1;
            return;
        end
        expQ.push_back(mAddr * 16 + op);
        mAddr++;
        if (op == 7) mDepth++;
        if (op == 8) mDepth--;
    endtask

    task automatic modelFinish();
        if (mDone || mErr) return;
        if (mDepth == 0) begin
            expQ.push_back(mAddr * 16);
            mDone = 1;
        end else begin
            mErr = 1;
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clock) begin
        if (reset === 1'b1 && pm_wren === 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                int e;
                e = expQ.pop_front();
                check("wr_addr", int'(pm_addr), e / 16);
                check("wr_data", int'(pm_data), e % 16);
            end
        end
    end

    task automatic checkStatus(input string tag);
        check({tag, "_done"}, int'(input_done), int'(mDone));
        check({tag, "_err"}, int'(bracket_err), int'(mErr));
        check({tag, "_full"}, int'(full), int'(mAddr == MAX_LEN - 1));
        check({tag, "_length"}, int'(length), mAddr);
        check({tag, "_pending"}, expQ.size(), 0);
    endtask

    task automatic press(input bit e, input bit f, input byte c, input int hold, input string tag);
        @(negedge clock);
        switches = c;
        enter    = e;
        finish   = f;
        if (f) modelFinish();
        else if (e) modelEnter(c);
        repeat (hold) @(negedge clock);
        enter  = 1'b0;
        finish = 1'b0;
        repeat (5) @(negedge clock);
        checkStatus(tag);
    endtask

    task automatic key(input byte c);
        press(1'b1, 1'b0, c, 6, "enter");
    endtask

    task automatic fin();
        press(1'b0, 1'b1, 8'h00, 6, "finish");
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        modelReset();
        check("rst_wren", int'(pm_wren), 0);
        check("rst_addr", int'(pm_addr), 0);
        check("rst_data", int'(pm_data), 0);
        check("rst_done", int'(input_done), 0);
        check("rst_err", int'(bracket_err), 0);
        check("rst_full", int'(full), 0);
        check("rst_length", int'(length), 0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset = 1'b0; enter = 1'b0; finish = 1'b0; switches = 8'h00;
        modelReset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        doReset();

        // Simple program
        key("+"); key("+"); key("."); fin();
        doReset();

        // Loop with an ignored character
        key("["); key("-"); key(8'h78); key("]"); fin();
        doReset();

        // Close bracket first, then a finish that must be ignored
        key("]"); fin(); key("+");
        doReset();

        // Unclosed bracket at finish
        key("["); fin();
        doReset();

        // Nesting overflow
        key("["); key("["); key("["); key("[");
        doReset();

        // Fill storage, extra characters dropped, END in the reserved slot
        for (int i = 0; i < MAX_LEN + 1; i++) key("+");
        fin();
        doReset();

        // Held enter: one write, three cycles after the edge that first samples it
        @(negedge clock);
        switches = "+";
        enter = 1'b1;
        modelEnter("+");
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clock);
            #1;
            if (pm_wren === 1'b1 && lat == 0) lat = n;
        end
        check("enter_latency_edges", lat, 4);
        repeat (44) @(negedge clock);
        enter = 1'b0;
        repeat (5) @(negedge clock);
        checkStatus("held");
        doReset();

        // Simultaneous enter and finish: finish wins
        press(1'b1, 1'b1, "+", 6, "both");
        doReset();

        // Reset mid-load discards progress
        key("+"); key("+");
        doReset();
        key("."); fin();
        doReset();

        // Randomised programs
        for (int p = 0; p < 25; p++) begin
            int n;
            n = $urandom_range(2, 11);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                if ($urandom_range(0, 9) == 0) fin();
                else key(pool[$urandom_range(0, pool.len() - 1)]);
            end
            fin();
            key(opChars[$urandom_range(0, 7)]);
            doReset();
        end

        repeat (5) @(negedge clock);
        check("final_pending", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
